pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Generic, parametrised pipeline stage register that replaces the fixed per-stage registers between ID/EX, EX/MEM and MEM/WB. It carries an opaque data bundle and a control bundle under a valid/ready handshake, so a stage can stall (backpressure) rather than only flush. It also supports a synchronous flush that turns its contents into a bubble, and counts bubbles delivered downstream for performance analysis.

## Interface
- DATA_W, 128, width of the data bundle (operands, offset, PC, register indices, packed by the instantiating stage)
- CTRL_W, 24, width of the control bundle (EX/MEM/WB control fields, packed)
- CNT_W, 16, width of the bubble counter
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous discard of all held entries (hazard/branch kill)
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  upstream data bundle
- in_ctrl  in  CTRL_W  upstream control bundle
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream accepts this cycle
- out_data  out  DATA_W  data of head entry; all zeros when out_valid=0
- out_ctrl  out  CTRL_W  control of head entry; all zeros when out_valid=0, so a bubble never writes memory or registers
- bubble_cnt  out  CNT_W  saturating count of bubble cycles

## Operation
- Push = in_valid & in_ready & !flush. Pop = out_valid & out_ready.
- Entries leave in arrival order. Each accepted entry appears exactly once on the output and is never duplicated or dropped, except by flush.
- Base mode (one entry):
  - Storage is a single entry, tracked by a full flag.
  - in_ready = !full | out_ready, a combinational path from out_ready.
  - Push and pop in the same cycle: the entry is replaced, giving a throughput of 1 entry per cycle.
- Flush:
  - Next cycle all entries are invalid and the stored data/ctrl are zero.
  - A same-cycle in_valid is dropped.
  - Flush dominates push and pop. A pop in the flush cycle still counts as delivered.
- bubble_cnt:
  - Increments on every cycle with out_ready=1 & out_valid=0.
  - Saturates at all ones.
  - Unaffected by flush; cleared only by reset.
- Reset (reset=0, asynchronous): out_valid=0, out_data=0, out_ctrl=0, bubble_cnt=0, all entries empty, in_ready=1. Handshakes are ignored while reset=0.
- Reset asserted mid-transfer discards all held entries immediately.

## Timing
- Latency: 1 cycle. An entry pushed at edge N is visible on out_valid/out_data after edge N.
- While out_valid=1 & out_ready=0, out_data and out_ctrl hold stable until the pop.
- Base mode: in_ready has a combinational dependency on out_ready, and throughput is 1 per cycle with no bubbles under continuous ready.
- Skid mode: in_ready is a pure register output. Throughput is still 1 per cycle. After out_ready falls, at most one further entry is accepted.
- First cycle after reset deassertion: push is accepted.

## Configuration
- PIPE_STAGE_REG_SKID_EN defined:
  - Adds a second (skid) entry, for an occupancy of 0..2.
  - in_ready is registered: it is 1 when the skid entry is empty.
  - A push while the main entry is occupied and not popping goes to the skid entry.
  - On a pop, the skid entry moves to main in the same edge.
  - Flush and reset clear both entries.
  - Removes the out_ready→in_ready combinational path, for long stall chains.
- Undefined: single-entry base mode as above.

## Test plan
- Streaming: in_valid=1 with data 1..8 and out_ready=1 constant → out_data 1..8 on consecutive cycles one cycle later, bubble_cnt=0.
- Backpressure: push A=0x11, B=0x22 with out_ready held 0 for 3 cycles, then 1.
  - Base mode: A held stable and in_ready=0 during the stall.
  - Skid mode: B is also accepted, then in_ready=0.
  - Both modes: output order A then B with nothing lost.
- Flush with full stage and in_valid=1 carrying C=0x33 → next cycle out_valid=0, out_ctrl=0, out_data=0; C never appears.
- Bubble count: out_ready=1 and in_valid=0 for 5 cycles after reset → bubble_cnt=5. With CNT_W=4 and 20 idle cycles → bubble_cnt=15.
- Async reset mid-stall: stage full (skid full in skid mode), assert reset between edges → outputs zero immediately. After release: in_ready=1 and old entries never emerge.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - valid/ready bundle carrying pipeline data and control
interface pipe_stage_reg_if #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 24
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (
        output valid,
        output data,
        output ctrl,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  ctrl,
        output ready
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with handshake, flush and bubble counter; PIPE_STAGE_REG_SKID_EN adds a skid entry
module pipe_stage_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    pipe_stage_reg_if.slave      in_if,
    pipe_stage_reg_if.master     out_if,
    output logic [CNT_W-1:0]     bubble_cnt
);

    logic              full_q, full_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic              push, pop;

    assign pop  = full_q & out_if.ready;
    assign push = in_if.valid & in_if.ready & ~flush;

`ifdef PIPE_STAGE_REG_SKID_EN
    logic              skid_full_q, skid_full_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              ready_q, ready_d;

    // in_ready comes straight from a flop so out_ready never reaches upstream combinationally
    assign in_if.ready = ready_q;

    // next state for main/skid entries: pop refills main from skid, push lands in main if free else in skid
    always_comb begin
        full_d      = full_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        ready_d     = ready_q;
        if (flush) begin
            full_d      = 1'b0;
            main_data_d = '0;
            main_ctrl_d = '0;
            skid_full_d = 1'b0;
            skid_data_d = '0;
            skid_ctrl_d = '0;
            ready_d     = 1'b1;
        end else begin
            if (pop) begin
                if (skid_full_q) begin
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                    skid_full_d = 1'b0;
                    skid_data_d = '0;
                    skid_ctrl_d = '0;
                end else begin
                    full_d      = 1'b0;
                    main_data_d = '0;
                    main_ctrl_d = '0;
                end
            end
            if (push) begin
                // push only happens with skid empty, so main is free whenever it is empty or popping
                if (!full_q || pop) begin
                    full_d      = 1'b1;
                    main_data_d = in_if.data;
                    main_ctrl_d = in_if.ctrl;
                end else begin
                    skid_full_d = 1'b1;
                    skid_data_d = in_if.data;
                    skid_ctrl_d = in_if.ctrl;
                end
            end
            ready_d = ~skid_full_d;
        end
    end

    // skid entry and registered ready; reset empties the stage and opens it for input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            ready_q     <= 1'b1;
        end else begin
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            ready_q     <= ready_d;
        end
    end
`else
    // a downstream pop frees the single slot in the same cycle, keeping full throughput
    assign in_if.ready = ~full_q | out_if.ready;

    // next state for the single entry: flush wins, a same-cycle push replaces a popped entry
    always_comb begin
        full_d      = full_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        if (flush) begin
            full_d      = 1'b0;
            main_data_d = '0;
            main_ctrl_d = '0;
        end else begin
            if (pop) begin
                full_d      = 1'b0;
                main_data_d = '0;
                main_ctrl_d = '0;
            end
            if (push) begin
                full_d      = 1'b1;
                main_data_d = in_if.data;
                main_ctrl_d = in_if.ctrl;
            end
        end
    end
`endif

    // main entry register; reset discards any held entry immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q      <= 1'b0;
            main_data_q <= '0;
            main_ctrl_q <= '0;
        end else begin
            full_q      <= full_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
        end
    end

    // saturating count of cycles where downstream was ready but got nothing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt <= '0;
        end else if (out_if.ready && !full_q && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    // gate the payload so a bubble never carries stale control downstream
    assign out_if.valid = full_q;
    assign out_if.data  = full_q ? main_data_q : '0;
    assign out_if.ctrl  = full_q ? main_ctrl_q : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [15:0] bubble_cnt;
    logic [3:0]  small_cnt;

    pipe_stage_reg_if #(.DATA_W(128), .CTRL_W(24)) in_if ();
    pipe_stage_reg_if #(.DATA_W(128), .CTRL_W(24)) out_if ();
    pipe_stage_reg_if #(.DATA_W(128), .CTRL_W(24)) s_in ();
    pipe_stage_reg_if #(.DATA_W(128), .CTRL_W(24)) s_out ();

    pipe_stage_reg #(.DATA_W(128), .CTRL_W(24), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_if      (in_if.slave),
        .out_if     (out_if.master),
        .bubble_cnt (bubble_cnt)
    );

    pipe_stage_reg #(.DATA_W(128), .CTRL_W(24), .CNT_W(4)) dut_small (
        .clk        (clk),
        .reset      (reset),
        .flush      (1'b0),
        .in_if      (s_in.slave),
        .out_if     (s_out.master),
        .bubble_cnt (small_cnt)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           failures = 0;
    logic [151:0] q[$];
    logic [15:0]  exp_bub = 16'd0;
    logic         acc;
    logic         sent;

    task automatic chk(input string tag, input logic [151:0] obs, input logic [151:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [151:0] mk(input int v);
        return {24'(v * 7 + 1), {4{32'(v)}}};
    endfunction

    // one clock: drive at negedge, check against the model, advance model across the edge
    task automatic cycle(input logic iv, input logic [151:0] pl, input logic ordy,
                         input logic fl, output logic accepted);
        logic exp_rdy;
        logic push;
        logic pop;
        in_if.valid  = iv;
        {in_if.ctrl, in_if.data} = pl;
        out_if.ready = ordy;
        flush        = fl;
        #1;
`ifdef PIPE_STAGE_REG_SKID_EN
        exp_rdy = (q.size() <= 1);
`else
        exp_rdy = (q.size() == 0) | ordy;
`endif
        chk("bubble_cnt", 152'(bubble_cnt), 152'(exp_bub));
        chk("out_valid", 152'(out_if.valid), 152'(q.size() != 0));
        chk("in_ready", 152'(in_if.ready), 152'(exp_rdy));
        if (q.size() != 0)
            chk("head", {out_if.ctrl, out_if.data}, q[0]);
        else
            chk("bubble_payload", {out_if.ctrl, out_if.data}, 152'd0);
        push = iv & exp_rdy & ~fl;
        pop  = (q.size() != 0) & ordy;
        if (ordy && q.size() == 0 && exp_bub != 16'hFFFF) exp_bub = exp_bub + 16'd1;
        if (pop) void'(q.pop_front());
        if (fl) q.delete();
        if (push) q.push_back(pl);
        accepted = push;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        in_if.valid = 1'b0; in_if.data = '0; in_if.ctrl = '0; out_if.ready = 1'b0;
        s_in.valid = 1'b0; s_in.data = '0; s_in.ctrl = '0; s_out.ready = 1'b1;

        @(negedge clk);
        #1;
        chk("rst_out_valid", 152'(out_if.valid), 152'd0);
        chk("rst_payload", {out_if.ctrl, out_if.data}, 152'd0);
        chk("rst_bubble", 152'(bubble_cnt), 152'd0);
        chk("rst_in_ready", 152'(in_if.ready), 152'd1);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) cycle(1'b0, 152'd0, 1'b1, 1'b0, acc);
        chk("bubble_five", 152'(bubble_cnt), 152'd5);

        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, mk(i), 1'b1, 1'b0, acc);
            chk("stream_accept", 152'(acc), 152'd1);
        end
        cycle(1'b0, 152'd0, 1'b1, 1'b0, acc);
        chk("stream_bubbles", 152'(bubble_cnt), 152'd6);

        cycle(1'b1, mk(8'h11), 1'b0, 1'b0, acc);
        sent = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle(~sent, mk(8'h22), 1'b0, 1'b0, acc);
            sent = sent | acc;
        end
`ifdef PIPE_STAGE_REG_SKID_EN
        chk("skid_took_b", 152'(sent), 152'd1);
`else
        chk("base_held_b", 152'(sent), 152'd0);
`endif
        for (int i = 0; i < 10 && (q.size() != 0 || !sent); i++) begin
            cycle(~sent, mk(8'h22), 1'b1, 1'b0, acc);
            sent = sent | acc;
        end
        chk("bp_drained", 152'(q.size() == 0 && sent), 152'd1);

        cycle(1'b1, mk(8'h44), 1'b0, 1'b0, acc);
`ifdef PIPE_STAGE_REG_SKID_EN
        cycle(1'b1, mk(8'h55), 1'b0, 1'b0, acc);
`endif
        cycle(1'b1, mk(8'h33), 1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) cycle(1'b0, 152'd0, 1'b1, 1'b0, acc);
        cycle(1'b1, mk(8'h66), 1'b1, 1'b0, acc);
        cycle(1'b0, 152'd0, 1'b1, 1'b1, acc);
        cycle(1'b0, 152'd0, 1'b1, 1'b0, acc);

        cycle(1'b1, mk(8'h77), 1'b0, 1'b0, acc);
`ifdef PIPE_STAGE_REG_SKID_EN
        cycle(1'b1, mk(8'h88), 1'b0, 1'b0, acc);
`endif
        #2;
        reset = 1'b0;
        #1;
        chk("arst_out_valid", 152'(out_if.valid), 152'd0);
        chk("arst_payload", {out_if.ctrl, out_if.data}, 152'd0);
        chk("arst_bubble", 152'(bubble_cnt), 152'd0);
        chk("arst_in_ready", 152'(in_if.ready), 152'd1);
        chk("arst_small", 152'(small_cnt), 152'd0);
        q.delete();
        exp_bub = 16'd0;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            if (i == 5) chk("small_cnt_5", 152'(small_cnt), 152'd5);
            cycle(1'($urandom_range(0, 1)), mk(int'($urandom_range(0, 255))),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), acc);
        end
        chk("small_cnt_sat", 152'(small_cnt), 152'd15);

        for (int i = 0; i < 10 && q.size() != 0; i++) cycle(1'b0, 152'd0, 1'b1, 1'b0, acc);
        chk("final_drain", 152'(q.size()), 152'd0);
        cycle(1'b0, 152'd0, 1'b1, 1'b0, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
